// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: issues one weight read per neuron on a shared MAC/sigmoid datapath and
// writes each tagged result back to the result buffer at its neuron index.
module neuron_layer_sequencer #(
   parameter int NUM_NEURONS = 16,
   parameter int ADDR_W      = 4,
   parameter int ROM_LAT     = 1,
   parameter int PIPE_LAT    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [135:0]      x_in,
   output logic [135:0]      x_out,
   output logic [ADDR_W-1:0] w_addr,
   output logic              w_rd_en,
   output logic              neuron_ce,
   input  logic [16:0]       y_in,
   output logic              res_we,
   output logic [ADDR_W-1:0] res_addr,
   output logic [16:0]       res_data,
   output logic              busy,
   output logic              done,
   output logic              start_err
);
   localparam int D  = ROM_LAT + PIPE_LAT;
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] NUM  = CW'(NUM_NEURONS);
   localparam logic [CW-1:0] LAST = CW'(NUM_NEURONS - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [D-2:0]      tag_v;
   logic [ADDR_W-1:0] tag_i [D-1];
   assign start_err = start & busy & ~rst;
   // the res_* registers form the final stage of the tag pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         tag_v     <= '0;
         for (int i = 0; i < D-1; i++) tag_i[i] <= '0;
         x_out     <= '0;
         w_addr    <= '0;
         w_rd_en   <= 1'b0;
         neuron_ce <= 1'b0;
         res_we    <= 1'b0;
         res_addr  <= '0;
         res_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         tag_v[0] <= w_rd_en;
         tag_i[0] <= w_addr;
         for (int i = 1; i < D-1; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_i[i] <= tag_i[i-1];
         end
         res_we <= tag_v[D-2];
         if (tag_v[D-2]) begin
            res_addr <= tag_i[D-2];
            res_data <= y_in;
         end
         w_rd_en <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: if (start) begin
               x_out     <= x_in;
               state     <= ISSUE;
               busy      <= 1'b1;
               neuron_ce <= 1'b1;
               w_rd_en   <= 1'b1;
               w_addr    <= '0;
               cnt       <= CW'(1);
            end
            ISSUE: if (cnt == NUM) state <= DRAIN;
            else begin
               w_rd_en <= 1'b1;
               w_addr  <= cnt[ADDR_W-1:0];
               cnt     <= cnt + CW'(1);
            end
            DRAIN: if (res_we && {1'b0, res_addr} == LAST) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               neuron_ce <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: checks a default-sized and a 1-neuron sequencer cycle by cycle
// against a timeline model of the layer (start cycle plus fixed offsets).
module tb_neuron_layer_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_a = 1'b1, start_a = 1'b0, rst_b = 1'b1, start_b = 1'b0;
   logic [135:0] x_in_a = '0, x_out_a, x_in_b = '0, x_out_b;
   logic [3:0]   w_addr_a, res_addr_a, w_addr_b, res_addr_b;
   logic         w_rd_en_a, neuron_ce_a, res_we_a, busy_a, done_a, start_err_a;
   logic         w_rd_en_b, neuron_ce_b, res_we_b, busy_b, done_b, start_err_b;
   logic [16:0]  y_in_a = '0, res_data_a, y_in_b = '0, res_data_b;

   neuron_layer_sequencer dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .x_in(x_in_a), .x_out(x_out_a),
      .w_addr(w_addr_a), .w_rd_en(w_rd_en_a), .neuron_ce(neuron_ce_a), .y_in(y_in_a),
      .res_we(res_we_a), .res_addr(res_addr_a), .res_data(res_data_a),
      .busy(busy_a), .done(done_a), .start_err(start_err_a));

   neuron_layer_sequencer #(.NUM_NEURONS(1), .ADDR_W(4), .ROM_LAT(2), .PIPE_LAT(3)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .x_in(x_in_b), .x_out(x_out_b),
      .w_addr(w_addr_b), .w_rd_en(w_rd_en_b), .neuron_ce(neuron_ce_b), .y_in(y_in_b),
      .res_we(res_we_b), .res_addr(res_addr_b), .res_data(res_data_b),
      .busy(busy_b), .done(done_b), .start_err(start_err_b));

   int total = 0, bad = 0, cyc = 0;
   int nn [2] = '{16, 1};
   int dd [2] = '{9, 5};
   int s  [2] = '{-1, -1};
   int nl [2] = '{0, 0};
   logic [135:0] xl [2];
   logic [3:0]   hwa [2], hra [2];
   logic [16:0]  hrd [2];
   logic [16:0]  yv [2][16];
   logic         st [2], rs [2];
   logic         e_busy [2], e_rd [2], e_we [2], e_done [2], e_err [2];
   logic [3:0]   e_wa [2], e_ra [2];
   logic [16:0]  e_dat [2];

   function automatic logic [135:0] r136();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[135:0];
   endfunction

   // y_in carries the result for the index issued D-1 cycles earlier, junk otherwise
   function automatic logic [16:0] yfor(int id);
      int idx;
      idx = cyc - s[id] - dd[id];
      if (s[id] >= 0 && idx >= 0 && idx < nn[id]) return yv[id][idx];
      return 17'($urandom);
   endfunction

   task automatic compute(int id);
      int k, l;
      k = (s[id] >= 0) ? cyc - s[id] : -1;
      l = nn[id] + dd[id] + 1;
      e_busy[id] = k >= 1 && k <= l;
      e_done[id] = k == l;
      e_rd[id]   = k >= 1 && k <= nn[id];
      e_wa[id]   = e_rd[id] ? 4'(k - 1) : hwa[id];
      e_we[id]   = k >= dd[id] + 1 && k <= dd[id] + nn[id];
      e_ra[id]   = hra[id];
      e_dat[id]  = hrd[id];
      if (e_we[id]) begin
         e_ra[id]  = 4'(k - dd[id] - 1);
         e_dat[id] = yv[id][k - dd[id] - 1];
      end
      e_err[id] = st[id] && e_busy[id] && !rs[id];
   endtask

   task automatic chk(string tag, logic [135:0] obs, logic [135:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s at cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check(int id, string n, logic [135:0] xo, logic [3:0] wa, logic rd, logic ce,
                        logic we, logic [3:0] ra, logic [16:0] rd_data, logic b, logic d, logic e);
      chk({n, ".x_out"}, xo, xl[id]);
      chk({n, ".w_addr"}, 136'(wa), 136'(e_wa[id]));
      chk({n, ".w_rd_en"}, 136'(rd), 136'(e_rd[id]));
      chk({n, ".neuron_ce"}, 136'(ce), 136'(e_busy[id]));
      chk({n, ".res_we"}, 136'(we), 136'(e_we[id]));
      chk({n, ".res_addr"}, 136'(ra), 136'(e_ra[id]));
      chk({n, ".res_data"}, 136'(rd_data), 136'(e_dat[id]));
      chk({n, ".busy"}, 136'(b), 136'(e_busy[id]));
      chk({n, ".done"}, 136'(d), 136'(e_done[id]));
      chk({n, ".start_err"}, 136'(e), 136'(e_err[id]));
   endtask

   task automatic update(int id, int c, logic [135:0] xi);
      if (rs[id]) begin
         s[id] = -1; xl[id] = '0; hwa[id] = '0; hra[id] = '0; hrd[id] = '0;
      end else begin
         hwa[id] = e_wa[id]; hra[id] = e_ra[id]; hrd[id] = e_dat[id];
         if (e_done[id]) s[id] = -1;
         else if (s[id] < 0 && st[id]) begin
            s[id] = c;
            xl[id] = xi;
            for (int i = 0; i < 16; i++)
               yv[id][i] = (nl[id] == 0) ? 17'(17'h100 + i) : 17'($urandom);
            nl[id]++;
         end
      end
   endtask

   task automatic step(bit sa, bit ra, bit sb, bit rb, bit do_chk = 1'b1);
      int c;
      st[0] = sa; rs[0] = ra; st[1] = sb; rs[1] = rb;
      start_a = sa; rst_a = ra; start_b = sb; rst_b = rb;
      x_in_a = r136(); x_in_b = r136();
      y_in_a = yfor(0); y_in_b = yfor(1);
      compute(0);
      compute(1);
      @(negedge clk);
      if (do_chk) begin
         check(0, "a", x_out_a, w_addr_a, w_rd_en_a, neuron_ce_a, res_we_a, res_addr_a,
               res_data_a, busy_a, done_a, start_err_a);
         check(1, "b", x_out_b, w_addr_b, w_rd_en_b, neuron_ce_b, res_we_b, res_addr_b,
               res_data_b, busy_b, done_b, start_err_b);
      end
      @(posedge clk);
      c = cyc;
      update(0, c, x_in_a);
      update(1, c, x_in_b);
      cyc++;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         xl[i] = '0; hwa[i] = '0; hra[i] = '0; hrd[i] = '0;
      end
      @(posedge clk);
      #1;
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1);
      // plain layer on both instances
      step(1, 0, 1, 0);
      repeat (30) step(0, 0, 0, 0);
      // start while busy at k=5 and in the done cycle, then back-to-back start
      step(1, 0, 1, 0);
      repeat (2) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (20) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (30) step(0, 0, 0, 0);
      // reset mid-layer, then a fresh layer
      step(1, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      repeat (7) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(1, 0, 0, 0);
      repeat (30) step(0, 0, 0, 0);
      // start and reset in the same cycle
      step(1, 1, 1, 1);
      repeat (3) step(0, 0, 0, 0);
      repeat (800)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
- Sequences one hidden layer on a single shared neuron datapath (8-input 17-bit MAC tree plus sigmoid LUT).
- Latches the layer input vector and streams one weight vector per neuron from a synchronous weight ROM.
- Tags each issue and tracks it through the fixed-latency pipeline.
- Writes each neuron output into a result buffer at its neuron index, then pulses done.

Parameters:
- NUM_NEURONS, 16, neurons in the layer; range 1..2^ADDR_W.
- ADDR_W, 4, width of the weight ROM address and result buffer address.
- ROM_LAT, 1, cycles from w_addr/w_rd_en to valid w_data at the datapath w port; range 1..4.
- PIPE_LAT, 8, cycles from x/w presented at the datapath to valid y; range 1..32.

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse to begin a layer; sampled only in IDLE.
- x_in, input, 136, concatenated previous-layer outputs (8 x 17 bits); sampled on an accepted start.
- x_out, output, 136, latched input vector driven to the datapath x port.
- w_addr, output, ADDR_W, weight ROM address (= neuron index).
- w_rd_en, output, 1, weight ROM read strobe.
- neuron_ce, output, 1, clock enable for the datapath adder tree.
- y_in, input, 17, datapath output.
- res_we, output, 1, result buffer write strobe.
- res_addr, output, ADDR_W, result buffer address (neuron index).
- res_data, output, 17, result word (registered copy of y_in).
- busy, output, 1, high from an accepted start until the done cycle inclusive.
- done, output, 1, one-cycle pulse after the last result is written.
- start_err, output, 1, one-cycle pulse when start arrives while busy.

Behaviour:
- Reset values: all outputs 0, x_out 0, state IDLE, issue counter 0, tag pipeline cleared. Reset mid-layer aborts immediately, with no further res_we and no done.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start, latch x_in into x_out and go to ISSUE. This is cycle 0. busy rises in cycle 1, registered.
- ISSUE: for cycles 1..NUM_NEURONS, w_rd_en=1 and w_addr = cycle-1 (0..NUM_NEURONS-1). After issuing index NUM_NEURONS-1, go to DRAIN.
- Tag pipeline: a shift register of depth ROM_LAT+PIPE_LAT carries {valid, index}. A valid tag is pushed on every w_rd_en cycle. When a tag emerges, that cycle asserts res_we=1, res_addr=index, res_data=y_in, sampled the same cycle.
- Result timing: the tag for the index issued in cycle t emerges in cycle t+ROM_LAT+PIPE_LAT.
- DRAIN: wait until the index NUM_NEURONS-1 result has been written, then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- neuron_ce=1 in ISSUE, DRAIN and DONE; 0 in IDLE. It is never deasserted mid-layer, because the multipliers are not gated and stalling would skew the pipeline.
- Outside write cycles: res_we=0 and res_addr/res_data hold their last values. w_rd_en=0 outside ISSUE, and w_addr holds its last value.
- x_out stays stable from cycle 1 until the next accepted start, so every neuron of the layer sees the same input vector.
- start while busy: ignored, start_err=1 for that cycle, layer unaffected. start in the same cycle as rst: rst wins, nothing is latched.
- start in the cycle after done (IDLE): accepted normally, giving back-to-back layers.
- NUM_NEURONS=1: single issue in cycle 1, single write in cycle 1+ROM_LAT+PIPE_LAT, done in the following cycle.
- Counters are ADDR_W+1 bits so index NUM_NEURONS-1 = 2^ADDR_W-1 terminates without wrap.
- Defaults give exactly 16 res_we pulses. Total layer time = NUM_NEURONS+ROM_LAT+PIPE_LAT+1 cycles from start to done.

Test Plan:
- Defaults, start at cycle 0 with x_in=136'h1234... -> w_rd_en cycles 1..16 with w_addr 0..15; res_we cycles 10..25 with res_addr 0..15; done and busy high in cycle 26; busy low in cycle 27; x_out equals x_in throughout.
- Datapath model returning y = 17'h100+index with PIPE_LAT=8 -> result buffer holds 17'h100..17'h10F at addresses 0..15, with no out-of-order writes.
- start pulsed again in cycle 5 of a layer -> start_err=1 in cycle 5; write sequence and done timing identical to the first test; x_out unchanged.
- rst asserted in cycle 12 -> from cycle 13 all outputs 0 and IDLE; no further res_we; no done. A new start in cycle 15 runs a full clean layer.
- NUM_NEURONS=1, ROM_LAT=2, PIPE_LAT=3 -> w_rd_en in cycle 1 only; res_we at res_addr 0 in cycle 6; done in cycle 7.
- Back-to-back: start in the cycle after done -> second layer w_rd_en begins the next cycle; 32 writes total with no gap in ordering.
